sb_event_scheduler: RTL and testbench
=====================================

# sb_event_scheduler

Serialises the four single-cycle sideband event pulses (read, write, transaction error, transaction valid) into one ordered event stream for the sideband register-access engine. It sits directly downstream of the level-to-pulse converters and upstream of the register-access engine. It holds every event until it is accepted and tracks completion with a timeout, so no pulse is lost while the engine is busy.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in WAIT without evt_done before abort; legal range 2..65535
- CNT_W, 8, width of each drop counter; only used with SB_EVT_STATS_EN

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; all state cleared on the edge where it is sampled high
- s_read_pul  in  1  read-request pulse
- s_write_pul  in  1  write-request pulse
- t_valid_pul  in  1  transaction-valid pulse
- trans_error_pul  in  1  transaction-error pulse
- evt_valid  out  1  event offered to the engine
- evt_code  out  2  0 read, 1 write, 2 t_valid, 3 trans_error
- evt_ready  in  1  engine accepts the event when evt_valid && evt_ready
- evt_done  in  1  engine finished the current event; single-cycle pulse
- evt_timeout  out  1  one-cycle pulse when WAIT expires
- busy  out  1  FSM not in IDLE, or any pending bit set
- drop_cnt  out  4*CNT_W  per-source saturating drop counts {err, tv, wr, rd}; present only with SB_EVT_STATS_EN

## Operation
- Each source has one pending bit. A pulse sets it at the next edge. A grant clears it at the same edge.
- Grant and a new pulse on the same source in the same cycle: pending stays 1, so the new event is queued.
- Pulse while that source's pending bit is already 1 and no grant occurs: the event is dropped. It is counted only with the macro enabled.
- Fixed priority, highest first: trans_error > t_valid > s_write > s_read.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pending bit is set, latch the winner into evt_code, clear its pending bit and go to ISSUE.
  - ISSUE: evt_valid=1; evt_code is held stable until acceptance. On acceptance, code 3 goes to IDLE (no completion expected) and other codes go to WAIT with the timer cleared to 0.
  - WAIT: evt_done=1 goes to IDLE. Otherwise the timer increments. When timer==TIMEOUT_CYCLES-1 without evt_done, assert evt_timeout for one cycle and go to IDLE.
- evt_done in IDLE or ISSUE is ignored.
- Timer width is $clog2(TIMEOUT_CYCLES+1).
- Reset mid-operation: pending bits cleared, FSM to IDLE, timer cleared, any offered event abandoned.
- Reset values: evt_valid=0, evt_code=0, evt_timeout=0, busy=0, drop_cnt=0.

## Timing
- Pulse sampled at edge E0 sets pending. E1 grants from IDLE. evt_valid is high in the cycle after E1, giving 2-cycle pulse-to-offer latency from idle.
- evt_valid, evt_code and evt_timeout are registered outputs. evt_ready and evt_done are not combinationally forwarded to any output.
- Minimum one IDLE cycle between events: done at edge Ed leaves IDLE for the cycle after Ed, and the next evt_valid rises one cycle later.
- Timeout: evt_timeout is high exactly TIMEOUT_CYCLES cycles after the acceptance edge, unless evt_done arrives first. evt_done arriving on the expiry cycle wins, and no timeout is signalled.

## Configuration
- SB_EVT_STATS_EN defined: the drop_cnt port and four CNT_W saturating counters exist. Each counter increments on a drop for its source, holds at all-ones, and clears only on reset.
- Not defined: the drop_cnt port and counters are absent. Drops are silent. All other behaviour is identical.

## Structure
- Shared package sb_evt_pkg holds:
  - the evt_code enum (EVT_RD, EVT_WR, EVT_TV, EVT_ERR)
  - the FSM state enum
  - the source index constants used for pending and drop_cnt slicing
- Sub-module sb_evt_prio_enc: a 4-bit pending-to-code fixed-priority encoder with a winner one-hot output. It is purely combinational and is instantiated once.

## Test plan
- Single s_write_pul, evt_ready tied 1, evt_done 3 cycles after acceptance -> evt_valid high for 1 cycle, 2 cycles after pulse, with evt_code=1; busy low after done.
- All four pulses in the same cycle, ready=1, done returned promptly -> codes issued in order 3, 2, 1, 0. Code 3 needs no done.
- TIMEOUT_CYCLES=4, s_read_pul, ready=1, no done -> evt_timeout pulses 4 cycles after acceptance; FSM returns to IDLE.
- With the macro, s_read_pul twice while code 0 is pending and the engine stalls (ready=0) -> one event issued; drop_cnt rd field=1. With CNT_W=2 and 5 drops, the field saturates at 3.
- Reset asserted while in WAIT with two pending bits set -> next cycle evt_valid=0, busy=0, and no events issued after reset deasserts.
- evt_done coincident with the expiry cycle -> no evt_timeout; FSM returns to IDLE.

Source files
------------

// File: rtl/sb_evt_pkg.sv
// Shared types and constants for the sideband event scheduler and its
// priority encoder.
package sb_evt_pkg;

  typedef enum logic [1:0] {
    EVT_RD  = 2'd0,
    EVT_WR  = 2'd1,
    EVT_TV  = 2'd2,
    EVT_ERR = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Bit positions in the pending vector and the drop_cnt fields.
  localparam int unsigned SRC_RD  = 0;
  localparam int unsigned SRC_WR  = 1;
  localparam int unsigned SRC_TV  = 2;
  localparam int unsigned SRC_ERR = 3;
  localparam int unsigned N_SRC   = 4;

endpackage

// File: rtl/sb_evt_prio_enc.sv
// Fixed-priority pending-to-code encoder:
// trans_error > t_valid > s_write > s_read.
module sb_evt_prio_enc
  import sb_evt_pkg::*;
(
  input  logic [3:0] req_i,
  output logic       any_o,
  output logic [1:0] code_o,
  output logic [3:0] win_oh_o
);

  always_comb begin
    code_o   = EVT_RD;
    win_oh_o = '0;
    if (req_i[SRC_ERR]) begin
      code_o            = EVT_ERR;
      win_oh_o[SRC_ERR] = 1'b1;
    end else if (req_i[SRC_TV]) begin
      code_o           = EVT_TV;
      win_oh_o[SRC_TV] = 1'b1;
    end else if (req_i[SRC_WR]) begin
      code_o           = EVT_WR;
      win_oh_o[SRC_WR] = 1'b1;
    end else if (req_i[SRC_RD]) begin
      code_o           = EVT_RD;
      win_oh_o[SRC_RD] = 1'b1;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sb_event_scheduler.sv
// Serialises four sideband event pulses into one ordered event stream with
// completion timeout. Build option SB_EVT_STATS_EN adds per-source drop counters.
module sb_event_scheduler
  import sb_evt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_read_pul,
  input  logic             s_write_pul,
  input  logic             t_valid_pul,
  input  logic             trans_error_pul,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  input  logic             evt_ready,
  input  logic             evt_done,
  output logic             evt_timeout,
  output logic             busy,
`ifdef SB_EVT_STATS_EN
  output logic [4*CNT_W-1:0] drop_cnt,
`endif
  output logic [1:0]       dbg_state
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] pul, grant;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             win_any;
  logic [1:0]       win_code;
  logic [N_SRC-1:0] win_oh;

  assign pul = {trans_error_pul, t_valid_pul, s_write_pul, s_read_pul};

  sb_evt_prio_enc u_prio_enc (
    .req_i    (pend_q),
    .any_o    (win_any),
    .code_o   (win_code),
    .win_oh_o (win_oh)
  );

  // A grant only happens from IDLE; a same-cycle pulse re-arms the bit.
  assign grant  = (state_q == ST_IDLE) ? win_oh : '0;
  assign pend_d = (pend_q & ~grant) | pul;

  // Handshake: an event transfers on the edge where evt_valid && evt_ready;
  // evt_code is stable from the rise of evt_valid until that edge, and
  // evt_done is a single-cycle completion pulse honoured only in WAIT.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_ISSUE;
          code_d  = win_code;
          valid_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          tmr_d   = '0;
          state_d = (code_q == EVT_ERR) ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (evt_done) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TMR_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      tmr_q   <= tmr_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_code    = code_q;
  assign evt_timeout = tmo_q;
  assign busy        = (state_q != ST_IDLE) | (|pend_q);
  assign dbg_state   = state_q;

`ifdef SB_EVT_STATS_EN
  logic [N_SRC-1:0] drop;
  assign drop = pul & pend_q & ~grant;

  for (genvar i = 0; i < N_SRC; i++) begin : g_drop
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (drop[i] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
    assign drop_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  // Without statistics, drops are silent and CNT_W has no hardware.
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_sb_event_scheduler.sv
// Directed bench for sb_event_scheduler: cycle model + scoreboard plus
// hand-computed literal checks. Drop counters are checked when SB_EVT_STATS_EN is set.
`timescale 1ns/1ps
module tb_sb_event_scheduler;
  import sb_evt_pkg::*;

  localparam int TMO      = 4;
  localparam int CW       = 2;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_read_pul = 1'b0;
  logic       s_write_pul = 1'b0;
  logic       t_valid_pul = 1'b0;
  logic       trans_error_pul = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_done = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_timeout;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef SB_EVT_STATS_EN
  logic [4*CW-1:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [1:0] exp_q[$];
  logic [1:0] acc_log[$];

  // Behavioural model state: pending flags, offer/wait flags, age since acceptance.
  bit m_pend[4];
  bit m_off, m_wait, m_to;
  int m_age, m_code;
  int m_drop[4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sb_event_scheduler #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_read_pul      (s_read_pul),
    .s_write_pul     (s_write_pul),
    .t_valid_pul     (t_valid_pul),
    .trans_error_pul (trans_error_pul),
    .evt_valid       (evt_valid),
    .evt_code        (evt_code),
    .evt_ready       (evt_ready),
    .evt_done        (evt_done),
    .evt_timeout     (evt_timeout),
    .busy            (busy),
`ifdef SB_EVT_STATS_EN
    .drop_cnt        (drop_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  always @(posedge clk) begin
    bit p[4];
    int g;
    p[0] = s_read_pul;
    p[1] = s_write_pul;
    p[2] = t_valid_pul;
    p[3] = trans_error_pul;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 1'b0;
        m_drop[i] = 0;
      end
      m_off  = 1'b0;
      m_wait = 1'b0;
      m_to   = 1'b0;
      m_age  = 0;
      m_code = 0;
      exp_q.delete();
    end else begin
      g    = -1;
      m_to = 1'b0;
      if (!m_off && !m_wait)
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && g < 0) g = i;
      for (int i = 0; i < 4; i++) begin
        if (p[i] && m_pend[i] && g != i && m_drop[i] < DROP_MAX) m_drop[i]++;
        m_pend[i] = (m_pend[i] && g != i) || p[i];
      end
      if (g >= 0) begin
        m_off  = 1'b1;
        m_code = g;
        exp_q.push_back(g[1:0]);
      end else if (m_off) begin
        if (evt_ready) begin
          m_off = 1'b0;
          if (m_code != 3) begin
            m_wait = 1'b1;
            m_age  = 0;
          end
        end
      end else if (m_wait) begin
        if (evt_done) m_wait = 1'b0;
        else begin
          m_age++;
          if (m_age == TMO) begin
            m_wait = 1'b0;
            m_to   = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- compare + scoreboard ----------------
  always @(negedge clk) begin
    bit busy_m;
    if (chk_en) begin
      busy_m = m_off || m_wait;
      for (int i = 0; i < 4; i++) busy_m = busy_m || m_pend[i];
      chk("evt_valid", evt_valid, m_off);
      chk("evt_code", evt_code, m_code);
      chk("evt_timeout", evt_timeout, m_to);
      chk("busy", busy, busy_m);
`ifdef SB_EVT_STATS_EN
      begin
        logic [4*CW-1:0] e;
        for (int i = 0; i < 4; i++) e[i*CW +: CW] = CW'(m_drop[i]);
        chk("drop_cnt", drop_cnt, e);
      end
`endif
      if (!reset && evt_valid && evt_ready) begin
        acc_log.push_back(evt_code);
        if (exp_q.size() == 0) chk("sb_unexpected_accept", 1, 0);
        else chk("sb_accept_code", evt_code, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(string name, int budget);
    int n = 0;
    @(negedge clk);
    while (!evt_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, evt_valid, 1);
  endtask

  // Accepts n events, returning evt_done one cycle after each non-error acceptance.
  task automatic serve(string name, int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] c;
      wait_valid(name, 20);
      c = evt_code;
      tick();
      if (c != 2'd3) begin
        evt_done = 1'b1;
        tick();
        evt_done = 1'b0;
      end
    end
  endtask

  task automatic check_log(string name, int n, int c0, int c1, int c2, int c3);
    int e[4];
    e[0] = c0; e[1] = c1; e[2] = c2; e[3] = c3;
    chk({name, "_count"}, acc_log.size(), n);
    for (int k = 0; k < n && k < acc_log.size(); k++)
      chk($sformatf("%s_%0d", name, k), acc_log[k], e[k]);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_timeout", evt_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
`ifdef SB_EVT_STATS_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Single write: offer 2 cycles after pulse, one cycle wide, done 3 cycles later.
    evt_ready   = 1'b1;
    s_write_pul = 1'b1;
    tick();
    s_write_pul = 1'b0;
    @(negedge clk);
    chk("t1_valid_after_e0", evt_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_valid_after_e1", evt_valid, 1);
    chk("t1_code", evt_code, 1);
    tick();
    @(negedge clk);
    chk("t1_valid_after_accept", evt_valid, 0);
    tick();
    tick();
    evt_done = 1'b1;
    tick();
    evt_done = 1'b0;
    @(negedge clk);
    chk("t1_busy_after_done", busy, 0);
    chk("t1_state_after_done", dbg_state, ST_IDLE);
    repeat (2) tick();

    // All four sources at once: strict priority order.
    acc_log.delete();
    s_read_pul = 1'b1; s_write_pul = 1'b1; t_valid_pul = 1'b1; trans_error_pul = 1'b1;
    tick();
    s_read_pul = 1'b0; s_write_pul = 1'b0; t_valid_pul = 1'b0; trans_error_pul = 1'b0;
    serve("t2_wait", 4);
    check_log("t2_order", 4, 3, 2, 1, 0);
    repeat (2) tick();

    // Pulse coincident with its own grant is queued, not dropped.
    acc_log.delete();
    s_read_pul = 1'b1;
    tick();
    tick();
    s_read_pul = 1'b0;
    serve("t3_wait", 2);
    check_log("t3_requeue", 2, 0, 0, 0, 0);
    repeat (2) tick();

    // Stalled engine: repeated reads while read is pending are dropped.
    acc_log.delete();
    evt_ready   = 1'b0;
    s_write_pul = 1'b1;
    tick();
    s_write_pul = 1'b0;
    s_read_pul  = 1'b1;
    tick();
    tick();
    s_read_pul = 1'b0;
`ifdef SB_EVT_STATS_EN
    @(negedge clk);
    chk("t4_drop_one", drop_cnt, 1);
`endif
    s_read_pul = 1'b1;
    repeat (4) tick();
    s_read_pul = 1'b0;
`ifdef SB_EVT_STATS_EN
    @(negedge clk);
    chk("t4_drop_sat", drop_cnt, 3);
`endif
    evt_ready = 1'b1;
    serve("t4_wait", 2);
    check_log("t4_issued", 2, 1, 0, 0, 0);
    repeat (2) tick();

    // Timeout: no done, evt_timeout exactly TMO cycles after acceptance.
    s_read_pul = 1'b1;
    tick();
    s_read_pul = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t5_timeout_%0d", i), evt_timeout, (i == 4) ? 1 : 0);
      if (i == 4) begin
        chk("t5_state_idle", dbg_state, ST_IDLE);
        chk("t5_busy", busy, 0);
      end
    end
    repeat (2) tick();

    // Done on the expiry cycle wins; a stray done in IDLE is ignored first.
    evt_done = 1'b1;
    tick();
    evt_done   = 1'b0;
    s_read_pul = 1'b1;
    tick();
    s_read_pul = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) evt_done = 1'b1;
      tick();
      evt_done = 1'b0;
      @(negedge clk);
      chk($sformatf("t6_no_timeout_%0d", i), evt_timeout, 0);
      if (i == 4) chk("t6_state_idle", dbg_state, ST_IDLE);
    end
    repeat (2) tick();

    // Reset while in WAIT with two pending sources.
    s_write_pul = 1'b1;
    tick();
    s_write_pul = 1'b0;
    tick();
    tick();
    s_read_pul  = 1'b1;
    t_valid_pul = 1'b1;
    tick();
    s_read_pul  = 1'b0;
    t_valid_pul = 1'b0;
    chk("t7_in_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    acc_log.delete();
    @(negedge clk);
    chk("t7_valid_after_reset", evt_valid, 0);
    chk("t7_busy_after_reset", busy, 0);
    repeat (10) tick();
    chk("t7_no_issue", acc_log.size(), 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
